axis_toggle_ctrl: RTL and testbench
===================================

// Module: axis_toggle_ctrl
// PURPOSE
//  Per-axis motion controller between the debounced RF-button/limit-switch
//  inputs and the stepper driver (dir/en). Turns momentary button presses into
//  latched (toggle) motion, stops and backs off at limit switches, enforces a
//  direction-reversal dead gap and a run-length timeout, and tracks position.
//  One instance per claw axis; all inputs are already debounced, in the clk domain.
// PARAMETERS
//  POS_W          16    width of signed position counter (wraps mod 2^POS_W)
//  MAX_STEPS      4000  step ticks per run before auto-stop (>=1)
//  REV_GAP        8     idle step ticks between a reversal request and new run (>=1)
//  BACKOFF_STEPS  4     step ticks driven away from a hit limit (>=1)
// PORTS
//  clk            in   1      system clock (only clock)
//  rst            in   1      synchronous, active-high reset
//  step_tick      in   1      1-clk pulse, one per motor step (from clock divider)
//  btn_fwd        in   1      debounced level, 1 = pressed
//  btn_rev        in   1      debounced level, 1 = pressed
//  limit_fwd      in   1      debounced, 1 = forward end-stop closed
//  limit_rev      in   1      debounced, 1 = reverse end-stop closed
//  dir            out  1      to driver; 1 = forward, 0 = reverse
//  en             out  1      to driver; 1 = stepping
//  at_limit       out  2      {rev,fwd} registered copies of limit inputs
//  position       out  POS_W  signed step count, +1 fwd / -1 rev
//  state_dbg      out  3      current state encoding (below)
// BEHAVIOUR
//  Reset: state=IDLE, en=0, dir=0, at_limit=0, position=0, all counters 0;
//   button-history regs reset to 1 so a button held through reset needs release.
//  Press = btn & ~btn_q (rising edge); press in cycle N -> new state/outputs at N+1.
//  en/dir are Moore outputs decoded from registered state (no comb path from inputs).
//  States: IDLE=0 RUN_FWD=1 RUN_REV=2 GAP=3 BACKOFF=4; others -> IDLE next clk.
//  IDLE: en=0, dir holds. fwd press & !limit_fwd -> RUN_FWD; rev press & !limit_rev
//   -> RUN_REV; both presses same cycle -> stay IDLE; press toward closed limit ignored.
//  RUN_FWD (en=1,dir=1); RUN_REV mirror. Priority high->low:
//   1 own-direction limit closed -> BACKOFF, dir = away, backoff cnt cleared
//   2 same-direction press -> IDLE (toggle off)
//   3 opposite press -> GAP, pending dir = opposite, gap cnt cleared
//   4 run_cnt == MAX_STEPS-1 on a step_tick -> IDLE
//   Both presses same cycle while running -> IDLE.
//  GAP: en=0. On step_tick gap cnt++; at REV_GAP ticks -> RUN_<pending> unless that
//   limit closed (-> IDLE). Any press during GAP -> IDLE (cancel).
//  BACKOFF: en=1, dir away from hit limit; presses ignored. BACKOFF_STEPS ticks -> IDLE;
//   opposite limit closing -> IDLE immediately.
//  run_cnt cleared on every RUN entry, ++ on step_tick while in RUN.
//  position: on step_tick with current en=1, +1 if dir else -1, modulo 2^POS_W
//   (0x7FFF+1 -> 0x8000). Tick coincident with a transition uses pre-transition en/dir.
//  at_limit: 1-clk registered copy of {limit_rev,limit_fwd}.
//  rst asserted mid-run: next clk IDLE, en=0, position=0, regardless of other inputs.
// TESTING
//  1 rst, btn_fwd 0->1 -> 1 clk later en=1,dir=1; 10 ticks -> position=10; btn_fwd
//    re-press -> en=0 next clk, position stays 10.
//  2 RUN_FWD, btn_rev press -> GAP (en=0) 8 ticks, then RUN_REV dir=0; 3 ticks ->
//    position decremented by 3.
//  3 RUN_FWD, limit_fwd=1 -> BACKOFF en=1,dir=0 for 4 ticks (position -4) then IDLE;
//    btn_fwd press with limit_fwd still 1 -> stays IDLE.
//  4 MAX_STEPS=5: start fwd, 5 ticks -> IDLE after 5th tick, position=5.
//  5 POS_W=4: from position 7, one fwd tick -> position 4'h8 (-8); rev from 0 -> 4'hF.
//  6 btn_fwd held high across rst release -> no motion until released and re-pressed;
//    rst during RUN_REV -> IDLE, en=0, position=0 next clk.

Source files
------------

// File: rtl/axis_toggle_ctrl.sv
// rtl/axis_toggle_ctrl.sv - per-axis toggle motion controller driving stepper dir/en
// Latches button presses into runs, backs off limits, gaps reversals, tracks position.
module axis_toggle_ctrl #(
    parameter int POS_W         = 16,
    parameter int MAX_STEPS     = 4000,
    parameter int REV_GAP       = 8,
    parameter int BACKOFF_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  logic             btn_fwd,
    input  logic             btn_rev,
    input  logic             limit_fwd,
    input  logic             limit_rev,
    output logic             dir,
    output logic             en,
    output logic [1:0]       at_limit,
    output logic [POS_W-1:0] position,
    output logic [2:0]       state_dbg
);

    localparam int RUN_W = $clog2(MAX_STEPS + 1);
    localparam int GAP_W = $clog2(REV_GAP + 1);
    localparam int BO_W  = $clog2(BACKOFF_STEPS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_FWD = 3'd1,
        RUN_REV = 3'd2,
        GAP     = 3'd3,
        BACKOFF = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic               pend_dir_q, pend_dir_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BO_W-1:0]    bo_cnt_q, bo_cnt_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic [1:0]         at_limit_q, at_limit_d;
    logic               btn_fwd_q, btn_rev_q;
    logic               press_fwd, press_rev, en_q;

    assign press_fwd = btn_fwd & ~btn_fwd_q;
    assign press_rev = btn_rev & ~btn_rev_q;
    assign en_q      = (state_q == RUN_FWD) || (state_q == RUN_REV) || (state_q == BACKOFF);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;
        run_cnt_d  = run_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        bo_cnt_d   = bo_cnt_q;
        at_limit_d = {limit_rev, limit_fwd};
        position_d = position_q;
        // Position uses the pre-transition en/dir of the current cycle
        if (step_tick && en_q)
            position_d = position_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});

        case (state_q)
            IDLE: begin
                if (press_fwd && !press_rev && !limit_fwd) begin
                    state_d   = RUN_FWD;
                    dir_d     = 1'b1;
                    run_cnt_d = '0;
                end else if (press_rev && !press_fwd && !limit_rev) begin
                    state_d   = RUN_REV;
                    dir_d     = 1'b0;
                    run_cnt_d = '0;
                end
            end
            RUN_FWD, RUN_REV: begin
                if ((state_q == RUN_FWD) ? limit_fwd : limit_rev) begin
                    state_d  = BACKOFF;
                    dir_d    = (state_q == RUN_REV);
                    bo_cnt_d = '0;
                end else if ((state_q == RUN_FWD) ? press_fwd : press_rev) begin
                    state_d = IDLE;
                end else if ((state_q == RUN_FWD) ? press_rev : press_fwd) begin
                    state_d    = GAP;
                    pend_dir_d = (state_q == RUN_REV);
                    gap_cnt_d  = '0;
                end else if (step_tick) begin
                    if (run_cnt_q == RUN_W'(MAX_STEPS - 1))
                        state_d = IDLE;
                    else
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            GAP: begin
                if (press_fwd || press_rev) begin
                    state_d = IDLE;
                end else if (step_tick) begin
                    if (gap_cnt_q == GAP_W'(REV_GAP - 1)) begin
                        if (pend_dir_q ? limit_fwd : limit_rev) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = pend_dir_q ? RUN_FWD : RUN_REV;
                            dir_d     = pend_dir_q;
                            run_cnt_d = '0;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
            BACKOFF: begin
                // The limit we are backing toward closing means the axis is boxed in
                if (dir_q ? limit_fwd : limit_rev) begin
                    state_d = IDLE;
                end else if (step_tick) begin
                    if (bo_cnt_q == BO_W'(BACKOFF_STEPS - 1))
                        state_d = IDLE;
                    else
                        bo_cnt_d = bo_cnt_q + BO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            pend_dir_q <= 1'b0;
            run_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            bo_cnt_q   <= '0;
            position_q <= '0;
            at_limit_q <= '0;
            btn_fwd_q  <= 1'b1;
            btn_rev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            run_cnt_q  <= run_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            bo_cnt_q   <= bo_cnt_d;
            position_q <= position_d;
            at_limit_q <= at_limit_d;
            btn_fwd_q  <= btn_fwd;
            btn_rev_q  <= btn_rev;
        end
    end

    assign dir       = dir_q;
    assign en        = en_q;
    assign at_limit  = at_limit_q;
    assign position  = position_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_axis_toggle_ctrl.sv
// tb/tb_axis_toggle_ctrl.sv - directed self-checking bench for axis_toggle_ctrl
module tb_axis_toggle_ctrl;

    logic        clk = 1'b0;
    logic        rst, step_tick, btn_fwd, btn_rev, limit_fwd, limit_rev;
    logic        dir_a, en_a, dir_b, en_b;
    logic [1:0]  at_limit_a, at_limit_b;
    logic [15:0] position_a;
    logic [3:0]  position_b;
    logic [2:0]  state_a, state_b;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    axis_toggle_ctrl u_dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .btn_fwd(btn_fwd), .btn_rev(btn_rev),
        .limit_fwd(limit_fwd), .limit_rev(limit_rev), .dir(dir_a), .en(en_a),
        .at_limit(at_limit_a), .position(position_a), .state_dbg(state_a)
    );

    axis_toggle_ctrl #(.POS_W(4), .MAX_STEPS(5)) u_small (
        .clk(clk), .rst(rst), .step_tick(step_tick), .btn_fwd(btn_fwd), .btn_rev(btn_rev),
        .limit_fwd(limit_fwd), .limit_rev(limit_rev), .dir(dir_b), .en(en_b),
        .at_limit(at_limit_b), .position(position_b), .state_dbg(state_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step_tick = 1'b1;
            cyc(1);
            step_tick = 1'b0;
        end
    endtask

    task automatic press_fwd();
        btn_fwd = 1'b1;
        cyc(1);
    endtask

    task automatic press_rev();
        btn_rev = 1'b1;
        cyc(1);
    endtask

    task automatic release_btns();
        btn_fwd = 1'b0;
        btn_rev = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; step_tick = 1'b0; btn_fwd = 1'b0; btn_rev = 1'b0;
        limit_fwd = 1'b0; limit_rev = 1'b0;
        cyc(2);
        check("rst_state", state_a, 0);
        check("rst_en", en_a, 0);
        check("rst_dir", dir_a, 0);
        check("rst_pos", position_a, 0);
        check("rst_limit", at_limit_a, 0);
        rst = 1'b0;
        cyc(1);

        // toggle run forward
        press_fwd();
        check("t1_en", en_a, 1);
        check("t1_dir", dir_a, 1);
        release_btns();
        ticks(10);
        check("t1_pos10", position_a, 10);
        press_fwd();
        check("t1_off_en", en_a, 0);
        check("t1_off_state", state_a, 0);
        release_btns();
        ticks(2);
        check("t1_pos_hold", position_a, 10);
        check("t1_dir_hold", dir_a, 1);

        // reversal through gap
        press_fwd();
        release_btns();
        ticks(2);
        check("t2_pos12", position_a, 12);
        press_rev();
        check("t2_gap", state_a, 3);
        check("t2_gap_en", en_a, 0);
        release_btns();
        ticks(7);
        check("t2_gap7", state_a, 3);
        ticks(1);
        check("t2_run_rev", state_a, 2);
        check("t2_rev_dir", dir_a, 0);
        check("t2_gap_pos", position_a, 12);
        ticks(3);
        check("t2_pos9", position_a, 9);
        press_rev();
        check("t2_stop", state_a, 0);
        release_btns();

        // both presses together from idle stay idle
        btn_fwd = 1'b1; btn_rev = 1'b1;
        cyc(1);
        check("both_idle", state_a, 0);
        release_btns();

        // limit backoff
        press_fwd();
        release_btns();
        ticks(1);
        check("t3_pos10", position_a, 10);
        limit_fwd = 1'b1;
        cyc(1);
        check("t3_backoff", state_a, 4);
        check("t3_bo_en", en_a, 1);
        check("t3_bo_dir", dir_a, 0);
        check("t3_at_limit", at_limit_a, 2'b01);
        ticks(3);
        check("t3_bo3", state_a, 4);
        ticks(1);
        check("t3_idle", state_a, 0);
        check("t3_pos6", position_a, 6);
        press_fwd();
        check("t3_blocked", state_a, 0);
        check("t3_blocked_en", en_a, 0);
        release_btns();
        limit_fwd = 1'b0;
        cyc(1);

        // run-length timeout and wrap on the small instance
        do_reset();
        press_fwd();
        release_btns();
        ticks(4);
        check("t4_run4", state_b, 1);
        ticks(1);
        check("t4_timeout", state_b, 0);
        check("t4_pos5", position_b, 5);
        press_fwd();
        release_btns();
        ticks(2);
        check("t5_pos7", position_b, 7);
        ticks(1);
        check("t5_wrap8", position_b, 4'h8);
        do_reset();
        press_rev();
        release_btns();
        ticks(1);
        check("t5_wrapF", position_b, 4'hF);

        // held button across reset, then reset mid-run
        btn_fwd = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("t6_held", state_a, 0);
        check("t6_held_en", en_a, 0);
        btn_fwd = 1'b0;
        cyc(1);
        press_fwd();
        check("t6_repress", state_a, 1);
        release_btns();
        press_fwd();
        release_btns();
        press_rev();
        release_btns();
        ticks(2);
        check("t6_pos_neg2", position_a, 16'hFFFE);
        rst = 1'b1; btn_fwd = 1'b1; step_tick = 1'b1;
        cyc(1);
        check("t6_rst_state", state_a, 0);
        check("t6_rst_en", en_a, 0);
        check("t6_rst_pos", position_a, 0);
        rst = 1'b0; btn_fwd = 1'b0; step_tick = 1'b0;
        cyc(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
